// File: rtl/dac_axis_packer.sv
// Packs RATIO = 256/IN_WIDTH DMA beats into one 256-bit word for the DAC driver.
// Define DAC_PACK_PAD_EN to zero-pad short tlast words instead of discarding them.
module dac_axis_packer #(
  parameter int unsigned IN_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [255:0]        m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  input  logic                flush,
  output logic [31:0]         word_count,
  output logic                partial_err
);

  localparam int unsigned OUT_WIDTH = 256;
  localparam int unsigned RATIO     = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);

  typedef enum logic {EMPTY, FULL} out_state_e;

  out_state_e           state_q;
  logic [LANE_W-1:0]    lane_q;
  logic [OUT_WIDTH-1:0] acc_q;
  logic [OUT_WIDTH-1:0] tdata_q;
  logic                 tlast_q;
  logic [31:0]          count_q;
  logic                 perr_q;

  logic [OUT_WIDTH-1:0] word_c;
  logic                 lane_end_c;
  logic                 complete_c;
  logic                 drain_c;
  logic                 tready_c;
  logic                 accept_c;

  assign lane_end_c = (lane_q == LANE_LAST);
`ifdef DAC_PACK_PAD_EN
  assign complete_c = lane_end_c | s_axis_tlast;
`else
  assign complete_c = lane_end_c;
`endif
  assign drain_c  = (state_q == FULL) && m_axis_tready;
  // Stall only a beat that would complete a word into a held, undrained register
  assign tready_c = !rst && !flush && (!complete_c || (state_q == EMPTY) || drain_c);
  assign accept_c = s_axis_tvalid && tready_c;

  // Lanes below the current one come from the accumulator, lanes above are zero
  always_comb begin
    word_c = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (LANE_W'(k) < lane_q) begin
        word_c[k*IN_WIDTH +: IN_WIDTH] = acc_q[k*IN_WIDTH +: IN_WIDTH];
      end else if (LANE_W'(k) == lane_q) begin
        word_c[k*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      lane_q  <= '0;
      acc_q   <= '0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      count_q <= '0;
      perr_q  <= 1'b0;
    end else if (flush) begin
      state_q <= EMPTY;
      lane_q  <= '0;
      acc_q   <= '0;
      tlast_q <= 1'b0;
      count_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      if (drain_c) begin
        count_q <= count_q + 32'd1;
      end
      if (accept_c && complete_c) begin
        tdata_q <= word_c;
        tlast_q <= s_axis_tlast;
        state_q <= FULL;
      end else if (drain_c) begin
        state_q <= EMPTY;
      end
      if (accept_c) begin
        if (complete_c || s_axis_tlast) begin
          lane_q <= '0;
          acc_q  <= '0;
        end else begin
          lane_q <= lane_q + LANE_W'(1);
          acc_q  <= word_c;
        end
`ifndef DAC_PACK_PAD_EN
        if (s_axis_tlast && !lane_end_c) begin
          perr_q <= 1'b1;
        end
`endif
      end
    end
  end

  assign s_axis_tready = tready_c;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = (state_q == FULL);
  assign m_axis_tlast  = tlast_q;
  assign word_count    = count_q;
  assign partial_err   = perr_q;

endmodule

// File: doc/dac_axis_packer.md
DAC_AXIS_PACKER -- requirements
Module: dac_axis_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 64: input beat width in bits; legal values 32, 64, 128.
REQ-002 SHALL derive RATIO = 256/IN_WIDTH, the number of input beats per output word.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port s_axis_tdata, input, IN_WIDTH: DMA sample data.
REQ-006 SHALL have port s_axis_tvalid, input, 1: input beat valid.
REQ-007 SHALL have port s_axis_tready, output, 1: input beat accepted when high with tvalid.
REQ-008 SHALL have port s_axis_tlast, input, 1: final beat of a waveform.
REQ-009 SHALL have port m_axis_tdata, output, 256: packed word to the dac_driver PS input.
REQ-010 SHALL have port m_axis_tvalid, output, 1: packed word valid.
REQ-011 SHALL have port m_axis_tready, input, 1: downstream ready.
REQ-012 SHALL have port m_axis_tlast, output, 1: word contains the waveform's final input beat.
REQ-013 SHALL have port flush, input, 1: synchronous discard of all buffered data.
REQ-014 SHALL have port word_count, output, 32: output words transferred since reset or flush.
REQ-015 SHALL have port partial_err, output, 1: one-cycle pulse on a discarded partial word.

Function
REQ-016 SHALL pack input beat k (k = 0..RATIO-1) of a word into m_axis_tdata[k*IN_WIDTH +: IN_WIDTH].
REQ-017 SHALL keep a lane counter 0..RATIO-1 that increments on each input transfer and wraps to 0 after lane RATIO-1 or after a tlast beat.
REQ-018 SHALL hold one output register with states EMPTY and FULL; EMPTY->FULL on word completion, FULL->EMPTY on an output transfer with no new completion, FULL->FULL when both occur in the same cycle.
REQ-019 SHALL drive s_axis_tready high when the accepted beat would not complete a word, or when the output register is EMPTY or being drained in the same cycle.
REQ-020 SHALL assert m_axis_tvalid the cycle after the completing input beat is accepted (latency 1).
REQ-021 SHALL sustain one input beat per cycle, and one output word per RATIO cycles, while m_axis_tready stays high.
REQ-022 SHALL hold m_axis_tdata and m_axis_tlast stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-023 SHALL set m_axis_tlast only on the word containing the tlast beat.
REQ-024 SHALL increment word_count by 1 per output transfer, wrapping from 0xFFFFFFFF to 0.
REQ-025 SHALL, on flush high, clear the lane counter, the accumulator, the output register state (m_axis_tvalid low next cycle) and word_count, ignoring any same-cycle input beat, with s_axis_tready held low that cycle.
REQ-026 SHALL give flush priority over all simultaneous input and output events.

Reset
REQ-027 SHALL, on rst, set s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, word_count=0, partial_err=0, lane counter=0, and output register state EMPTY.
REQ-028 SHALL drive s_axis_tready high in the first cycle after rst deasserts.
REQ-029 SHALL discard any partially accumulated word when rst asserts mid-word.

Configuration
REQ-030 SHALL, with DAC_PACK_PAD_EN defined, complete a word on a tlast beat at lane < RATIO-1, zero-fill the unwritten upper lanes, emit the word with m_axis_tlast=1, and hold partial_err at 0.
REQ-031 SHALL, without DAC_PACK_PAD_EN, discard a word whose tlast beat arrives at lane < RATIO-1, emit nothing for it, and pulse partial_err for one cycle after that beat is accepted.

Verification
REQ-032 SHALL cover: IN_WIDTH=64, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with ready high -> one word, 0x44..44 in bits [255:192], tvalid one cycle after beat 4, word_count=1.
REQ-033 SHALL cover: 8 beats back-to-back with m_axis_tready low from beat 4 -> tready low at beat 8 until m_axis_tready rises, word 1 held stable, no data loss.
REQ-034 SHALL cover: 3 beats, tlast on beat 3, DAC_PACK_PAD_EN defined -> word with bits [255:192]=0 and tlast=1; macro undefined -> no word and partial_err pulse.
REQ-035 SHALL cover: flush asserted with 2 lanes filled and FULL output register -> tvalid=0 next cycle, word_count=0, next 4 beats form a clean word.
REQ-036 SHALL cover: rst asserted mid-word at lane 2 -> all outputs at reset values, and the following 4 beats produce a word starting at lane 0.
